pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB) with a 16-entry register file.
- Works alongside the EX-stage forwarding logic. Detects load-use hazards that forwarding cannot cover, flushes on taken branches, freezes the pipe during multi-cycle data-memory accesses, and sequences halt/drain.
- Drives the write enables and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes,
// data-memory freezes and HALT drain. Optional counters under `HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_halt,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic              id_ex_memread,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              id_ex_we,
  output logic              ex_mem_we,
  output logic              mem_wb_we,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              mem_wb_bubble,
  output logic              halted,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;
  logic             freeze;
  logic             load_use;
  logic             branch_flush;

  // Data-memory handshake: mem_req is held by MEM until the cycle mem_ack is
  // high; that ack cycle completes the access and counts as unfrozen.
  assign freeze = mem_req & ~mem_ack & (state != HALTED);

  assign load_use = id_ex_memread & (id_ex_rd != '0) &
                    ((id_uses_rs & (id_rs == id_ex_rd)) |
                     (id_uses_rt & (id_rt == id_ex_rd)));

  assign branch_flush = ~rst & (state == RUN) & ~freeze & ex_branch_taken;
  assign state_dbg    = state;

  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    ex_mem_we     = 1'b1;
    mem_wb_we     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    halted        = 1'b0;
    if (!rst) begin
      if (state == HALTED) begin
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        id_ex_we  = 1'b0;
        ex_mem_we = 1'b0;
        mem_wb_we = 1'b0;
        halted    = 1'b1;
      end else if (freeze) begin
        // MEM/WB keeps writing so the bubble actually enters WB.
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        id_ex_we      = 1'b0;
        ex_mem_we     = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (state == DRAIN) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (id_halt) begin
        pc_we       = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!freeze && !ex_branch_taken && !load_use && id_halt) begin
            state     <= DRAIN;
            drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (!freeze) begin
            if (drain_cnt == '0) state <= HALTED;
            else drain_cnt <= drain_cnt - 1'b1;
          end
        end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_we && state != HALTED && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (branch_flush && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each task applies hand-computed vectors
// and compares the packed control word {we x5, flushes x2, bubble, halted}.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_rs, id_rt, id_ex_rd;
  logic        id_uses_rs, id_uses_rt, id_halt, id_ex_memread;
  logic        ex_branch_taken, mem_req, mem_ack;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, mem_wb_bubble, halted;
  logic [15:0] stall_cycles, flush_count;
  logic [1:0]  state_dbg;
  logic [8:0]  ctl;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [8:0] C_ALL    = 9'b11111_00_0_0;
  localparam logic [8:0] C_LU     = 9'b00111_01_0_0;
  localparam logic [8:0] C_BR     = 9'b11111_11_0_0;
  localparam logic [8:0] C_FRZ    = 9'b00001_00_1_0;
  localparam logic [8:0] C_HALT   = 9'b01111_10_0_0;
  localparam logic [8:0] C_DRAIN  = 9'b00111_01_0_0;
  localparam logic [8:0] C_HALTED = 9'b00000_00_0_1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_halt(id_halt), .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .state_dbg(state_dbg)
  );

  assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                if_id_flush, id_ex_flush, mem_wb_bubble, halted};

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_ex_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_halt = 0; id_ex_memread = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    mem_req = 1;
    settle();
    vectors++;
    if (ctl !== C_ALL) begin
      miscompares++; $display("FAIL reset_outputs got %b exp %b", ctl, C_ALL);
    end
    tick();
    rst = 0; mem_req = 0;
    settle();
    vectors++;
    if (ctl !== C_ALL || state_dbg !== 2'd0) begin
      miscompares++; $display("FAIL post_reset got %b/%0d exp %b/0", ctl, state_dbg, C_ALL);
    end
    vectors++;
    if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
      miscompares++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cycles, flush_count);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    id_ex_memread = 1; id_ex_rd = 4'd5; id_rs = 4'd5; id_uses_rs = 1;
    settle();
    vectors++;
    if (ctl !== C_LU) begin
      miscompares++; $display("FAIL load_use_rs got %b exp %b", ctl, C_LU);
    end
    tick();
    id_ex_memread = 0;
    settle();
    vectors++;
    if (ctl !== C_ALL) begin
      miscompares++; $display("FAIL load_use_release got %b exp %b", ctl, C_ALL);
    end
    tick();
    clear_inputs();
    id_ex_memread = 1; id_ex_rd = 4'd9; id_rt = 4'd9; id_uses_rt = 1; id_rs = 4'd3; id_uses_rs = 1;
    settle();
    vectors++;
    if (ctl !== C_LU) begin
      miscompares++; $display("FAIL load_use_rt got %b exp %b", ctl, C_LU);
    end
    tick();
    id_uses_rt = 0;
    settle();
    vectors++;
    if (ctl !== C_ALL) begin
      miscompares++; $display("FAIL load_use_unused_rt got %b exp %b", ctl, C_ALL);
    end
    tick();
    clear_inputs();
    id_ex_memread = 1; id_ex_rd = 4'd0; id_rs = 4'd0; id_uses_rs = 1;
    settle();
    vectors++;
    if (ctl !== C_ALL || pc_we !== 1'b1) begin
      miscompares++; $display("FAIL reg_zero got %b exp %b", ctl, C_ALL);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    do_reset();
    ex_branch_taken = 1;
    id_ex_memread = 1; id_ex_rd = 4'd7; id_rs = 4'd7; id_uses_rs = 1; id_halt = 1;
    settle();
    vectors++;
    if (ctl !== C_BR) begin
      miscompares++; $display("FAIL branch_over_load_use got %b exp %b", ctl, C_BR);
    end
    tick();
    clear_inputs();
    settle();
    vectors++;
    if (ctl !== C_ALL || state_dbg !== 2'd0) begin
      miscompares++; $display("FAIL branch_discards_halt got %b/%0d exp %b/0", ctl, state_dbg, C_ALL);
    end
`ifdef HAZARD_PERF_EN
    vectors++;
    if (flush_count !== 16'd1) begin
      miscompares++; $display("FAIL flush_count got %0d exp 1", flush_count);
    end
`else
    vectors++;
    if (flush_count !== 16'd0) begin
      miscompares++; $display("FAIL flush_count_tied got %0d exp 0", flush_count);
    end
`endif
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1; mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      vectors++;
      if (ctl !== C_FRZ) begin
        miscompares++; $display("FAIL mem_wait_%0d got %b exp %b", i, ctl, C_FRZ);
      end
      tick();
    end
    mem_ack = 1;
    settle();
    vectors++;
    if (ctl !== C_ALL) begin
      miscompares++; $display("FAIL mem_ack_cycle got %b exp %b", ctl, C_ALL);
    end
    tick();
    clear_inputs();
    settle();
`ifdef HAZARD_PERF_EN
    vectors++;
    if (stall_cycles !== 16'd3) begin
      miscompares++; $display("FAIL stall_cycles got %0d exp 3", stall_cycles);
    end
`else
    vectors++;
    if (stall_cycles !== 16'd0) begin
      miscompares++; $display("FAIL stall_cycles_tied got %0d exp 0", stall_cycles);
    end
`endif
    mem_req = 1; ex_branch_taken = 1;
    settle();
    vectors++;
    if (ctl !== C_FRZ) begin
      miscompares++; $display("FAIL freeze_over_branch got %b exp %b", ctl, C_FRZ);
    end
    tick();
    mem_ack = 1;
    settle();
    vectors++;
    if (ctl !== C_BR) begin
      miscompares++; $display("FAIL branch_after_freeze got %b exp %b", ctl, C_BR);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_halt_drain();
    logic [8:0] exp_seq [6];
    exp_seq = '{C_HALT, C_DRAIN, C_FRZ, C_DRAIN, C_DRAIN, C_HALTED};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      if (c == 0) id_halt = 1;
      if (c == 2) mem_req = 1;
      settle();
      vectors++;
      if (ctl !== exp_seq[c]) begin
        miscompares++; $display("FAIL halt_drain_cycle%0d got %b exp %b", c, ctl, exp_seq[c]);
      end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      mem_req = 1; ex_branch_taken = 1; id_halt = 1;
      settle();
      vectors++;
      if (ctl !== C_HALTED || state_dbg !== 2'd2) begin
        miscompares++; $display("FAIL halted_sticky_%0d got %b/%0d exp %b/2", c, ctl, state_dbg, C_HALTED);
      end
      tick();
    end
    do_reset();
    settle();
    vectors++;
    if (ctl !== C_ALL || state_dbg !== 2'd0) begin
      miscompares++; $display("FAIL halted_reset got %b/%0d exp %b/0", ctl, state_dbg, C_ALL);
    end
    tick();
  endtask

  task automatic test_reset_freeze();
    do_reset();
    mem_req = 1; mem_ack = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    settle();
    vectors++;
    if (ctl !== C_FRZ || state_dbg !== 2'd0) begin
      miscompares++; $display("FAIL reset_mid_freeze_held got %b/%0d exp %b/0", ctl, state_dbg, C_FRZ);
    end
    vectors++;
    if (stall_cycles !== 16'd0) begin
      miscompares++; $display("FAIL reset_mid_freeze_cnt got %0d exp 0", stall_cycles);
    end
    mem_req = 0;
    settle();
    vectors++;
    if (ctl !== C_ALL) begin
      miscompares++; $display("FAIL reset_mid_freeze_run got %b exp %b", ctl, C_ALL);
    end
    tick();
    id_halt = 1;
    tick();
    id_halt = 0; mem_req = 1;
    tick();
    rst = 1;
    tick();
    rst = 0; mem_req = 0;
    settle();
    vectors++;
    if (ctl !== C_ALL || state_dbg !== 2'd0) begin
      miscompares++; $display("FAIL reset_mid_drain got %b/%0d exp %b/0", ctl, state_dbg, C_ALL);
    end
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_halt_drain();
    test_reset_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
